// File: rtl/main_memory_responder.sv
// main_memory_responder
//   Multi-cycle main-memory slave on the memory side of the data cache. A
//   request (rd_en/wr_en) is accepted in IDLE, waits LATENCY-1 further edges,
//   then completes with a one-cycle ready pulse. Writes commit, and reads load
//   rd_data, on the edge that enters RESP.
//
//   Optional feature macro: MEMRESP_ERR_EN
//     defined   : adds port err; out-of-range or misaligned addresses complete
//                 with err=1 alongside ready, no array write, rd_data=0.
//     undefined : no err port; addresses alias modulo the array size.
//
//   Ports
//     clk      in   1           rising-edge clock
//     reset    in   1           synchronous, active-high
//     rd_en    in   1           read request (held by the cache until ready)
//     wr_en    in   1           write request (wins over rd_en when both high)
//     address  in   ADDR_WIDTH  byte address; word index = address[DEPTH_LOG2+1:2]
//     wr_data  in   DATA_WIDTH  write word
//     rd_data  out  DATA_WIDTH  read word, held until the next read completes
//     ready    out  1           one-cycle completion pulse
//     err      out  1           error completion (MEMRESP_ERR_EN only)
//     done     out  1           high while IDLE, a new request can be accepted
module main_memory_responder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  ready,
`ifdef MEMRESP_ERR_EN
    output logic                  err,
`endif
    output logic                  done
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic                    op_wr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic                    ready_q;
    logic                    done_q;
`ifdef MEMRESP_ERR_EN
    logic                    err_q;
`endif

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    accept;
    logic                    enter_resp;
    logic                    cmt_wr;
    logic                    cmt_bad;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   cmt_addr;
    logic [DATA_WIDTH-1:0]   cmt_data;
    logic [DEPTH_LOG2-1:0]   cmt_idx;

    // The commit happens on the edge entering RESP. With LATENCY=1 that is the
    // accepting edge itself, so the live inputs are used instead of the
    // captured copies.
    always_comb begin
        accept = (state_q == IDLE) && (rd_en || wr_en);
        if (state_q == IDLE) begin
            cmt_wr   = wr_en;
            cmt_addr = address;
            cmt_data = wr_data;
        end else begin
            cmt_wr   = op_wr_q;
            cmt_addr = addr_q;
            cmt_data = wdata_q;
        end
        enter_resp = (accept && (LATENCY == 1)) ||
                     ((state_q == BUSY) && (cnt_q == '0));
        cmt_idx    = cmt_addr[DEPTH_LOG2+1:2];
`ifdef MEMRESP_ERR_EN
        cmt_bad    = ((cmt_addr >> (DEPTH_LOG2 + 2)) != '0) ||
                     (cmt_addr[1:0] != 2'b00);
`else
        cmt_bad    = 1'b0;
`endif
        // Reset on the entering edge abandons the transaction before commit.
        mem_we     = enter_resp && cmt_wr && !cmt_bad && !reset;
    end

`ifndef MEMRESP_ERR_EN
    // Upper and byte-offset address bits are intentionally ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^cmt_addr;
`endif

    // Array storage: deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[cmt_idx] <= cmt_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            ready_q   <= 1'b0;
            done_q    <= 1'b1;
`ifdef MEMRESP_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            ready_q <= 1'b0;
`ifdef MEMRESP_ERR_EN
            err_q   <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_wr_q <= wr_en;
                        addr_q  <= address;
                        wdata_q <= wr_data;
                        done_q  <= 1'b0;
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
            endcase

            if (enter_resp) begin
                ready_q <= 1'b1;
`ifdef MEMRESP_ERR_EN
                err_q   <= cmt_bad;
`endif
                if (cmt_bad) begin
                    rd_data_q <= '0;
                end else if (!cmt_wr) begin
                    rd_data_q <= mem_q[cmt_idx];
                end
            end
        end
    end

    assign rd_data = rd_data_q;
    assign ready   = ready_q;
    assign done    = done_q;
`ifdef MEMRESP_ERR_EN
    assign err     = err_q;
`endif

endmodule

// File: tb/tb_main_memory_responder.sv
// tb_main_memory_responder
//   Directed bench: one responder with LATENCY=4 and one with LATENCY=1,
//   sharing clock and reset. Expected values are hand-computed constants.
module tb_main_memory_responder;

    logic        clk;
    logic        reset;

    logic        rd_en, wr_en;
    logic [31:0] address, wr_data, rd_data;
    logic        ready, done;

    logic        rd_b, wr_b;
    logic [31:0] addr_b, wdata_b, rdata_b;
    logic        ready_b, done_b;

`ifdef MEMRESP_ERR_EN
    logic        err, err_b;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    int          edges;
    logic        err_seen;

    main_memory_responder #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH_LOG2 (10),
        .LATENCY    (4)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (rd_en),
        .wr_en   (wr_en),
        .address (address),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .ready   (ready),
`ifdef MEMRESP_ERR_EN
        .err     (err),
`endif
        .done    (done)
    );

    main_memory_responder #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH_LOG2 (10),
        .LATENCY    (1)
    ) u_dut1 (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (rd_b),
        .wr_en   (wr_b),
        .address (addr_b),
        .wr_data (wdata_b),
        .rd_data (rdata_b),
        .ready   (ready_b),
`ifdef MEMRESP_ERR_EN
        .err     (err_b),
`endif
        .done    (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a request on the LATENCY=4 instance, count edges until ready
    // (bounded), drop the request, and let the FSM return to IDLE.
    task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, output int n_edges, output logic e);
        rd_en   = rd;
        wr_en   = wr;
        address = a;
        wr_data = d;
        n_edges = 0;
        e       = 1'b0;
        do begin
            step();
            n_edges++;
        end while (!ready && n_edges < 20);
`ifdef MEMRESP_ERR_EN
        e = err;
`endif
        rd_en = 1'b0;
        wr_en = 1'b0;
        step();
    endtask

    initial begin
        reset   = 1'b1;
        rd_en   = 1'b0; wr_en = 1'b0; address = '0; wr_data = '0;
        rd_b    = 1'b0; wr_b  = 1'b0; addr_b  = '0; wdata_b = '0;

        // 1. reset held two cycles
        repeat (2) step();
        reset = 1'b0;
        step();
        check("rst_ready",   {31'd0, ready},   32'd0);
        check("rst_done",    {31'd0, done},    32'd1);
        check("rst_rd_data", rd_data,          32'd0);
        check("rst_done_b",  {31'd0, done_b},  32'd1);

        // 2. write 0x10 with per-edge timing, then read back
        wr_en = 1'b1; address = 32'h10; wr_data = 32'hDEADBEEF;
        step(); // E0
        check("w_e0_done",  {31'd0, done},  32'd0);
        check("w_e0_ready", {31'd0, ready}, 32'd0);
        step(); // E1
        check("w_e1_ready", {31'd0, ready}, 32'd0);
        check("w_e1_done",  {31'd0, done},  32'd0);
        step(); // E2
        check("w_e2_ready", {31'd0, ready}, 32'd0);
        step(); // E3
        check("w_e3_ready", {31'd0, ready}, 32'd1);
        check("w_e3_done",  {31'd0, done},  32'd0);
        wr_en = 1'b0;
        step(); // E4
        check("w_e4_ready", {31'd0, ready}, 32'd0);
        check("w_e4_done",  {31'd0, done},  32'd1);

        txn(1'b1, 1'b0, 32'h10, 32'h0, edges, err_seen);
        check("r10_edges", edges,   32'd4);
        check("r10_data",  rd_data, 32'hDEADBEEF);
        check("r10_done",  {31'd0, done}, 32'd1);
`ifdef MEMRESP_ERR_EN
        check("r10_err",   {31'd0, err_seen}, 32'd0);
`endif

        // 3. rd and wr together: write wins, rd_data untouched
        txn(1'b1, 1'b1, 32'h20, 32'h12345678, edges, err_seen);
        check("rw20_edges", edges,   32'd4);
        check("rw20_rd_keep", rd_data, 32'hDEADBEEF);
        txn(1'b1, 1'b0, 32'h20, 32'h0, edges, err_seen);
        check("r20_data", rd_data, 32'h12345678);

        // 4. reset during BUSY abandons the write
        txn(1'b0, 1'b1, 32'h30, 32'h11111111, edges, err_seen);
        wr_en = 1'b1; address = 32'h30; wr_data = 32'hAAAA5555;
        step(); // E0
        check("abort_e0_done", {31'd0, done}, 32'd0);
        reset = 1'b1;
        step(); // E1 with reset sampled
        check("abort_done",    {31'd0, done},  32'd1);
        check("abort_ready",   {31'd0, ready}, 32'd0);
        check("abort_rd_data", rd_data,        32'd0);
        reset = 1'b0; wr_en = 1'b0;
        repeat (4) begin
            step();
            check("abort_no_ready", {31'd0, ready}, 32'd0);
        end
        txn(1'b1, 1'b0, 32'h30, 32'h0, edges, err_seen);
        check("r30_data", rd_data, 32'h11111111);

        // 6. out-of-range address: error or alias onto word 0
        txn(1'b0, 1'b1, 32'h0, 32'h55AA55AA, edges, err_seen);
        txn(1'b0, 1'b1, 32'h1000, 32'hCAFEF00D, edges, err_seen);
        check("w1000_edges", edges, 32'd4);
`ifdef MEMRESP_ERR_EN
        check("w1000_err",  {31'd0, err_seen}, 32'd1);
        check("w1000_rd0",  rd_data, 32'd0);
        txn(1'b1, 1'b0, 32'h0, 32'h0, edges, err_seen);
        check("r0_after_err", rd_data, 32'h55AA55AA);
`else
        txn(1'b1, 1'b0, 32'h0, 32'h0, edges, err_seen);
        check("r0_alias", rd_data, 32'hCAFEF00D);
`endif

        // 5. LATENCY=1: ready one cycle after acceptance, back-to-back reads
        wr_b = 1'b1; addr_b = 32'h4; wdata_b = 32'h0000ABCD;
        step();
        check("b_w_ready", {31'd0, ready_b}, 32'd1);
        check("b_w_done",  {31'd0, done_b},  32'd0);
        wr_b = 1'b0;
        step();
        check("b_w_idle_ready", {31'd0, ready_b}, 32'd0);
        check("b_w_idle_done",  {31'd0, done_b},  32'd1);

        rd_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("b2b_ready", {31'd0, ready_b}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("b2b_done",  {31'd0, done_b},  (i % 2 == 0) ? 32'd0 : 32'd1);
        end
        rd_b = 1'b0;
        check("b2b_data", rdata_b, 32'h0000ABCD);
        step();
        check("b_final_ready", {31'd0, ready_b}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
